// File: rtl/dispatch_pkg.sv
// Shared types and constants for the command dispatcher.
// Optional feature macro: CMD_DISPATCH_TIMEOUT_EN (per-command watchdog).
package dispatch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        REPLY   = 2'd2,
        WAIT_TX = 2'd3
    } dispatch_state_t;

    localparam logic [7:0] REPLY_ACK = 8'h06;
    localparam logic [7:0] REPLY_NAK = 8'h15;
    localparam logic [7:0] REPLY_TMO = 8'hEE;
    localparam logic [7:0] REPLY_ABT = 8'h18;
    localparam logic [7:0] CMD_ABORT = 8'h18;

endpackage

// File: rtl/dispatch_watchdog.sv
// Per-command watchdog: counts enabled cycles since the last clear and
// flags the cycle on which the count reaches TIMEOUT_CYCLES-1.
module dispatch_watchdog #(
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: clear wins over enable; holds otherwise.
    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en)
            cnt_d = cnt_q + 1'b1;
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign tc = (cnt_q == TC_VAL);

endmodule

// File: rtl/cmd_dispatcher.sv
// Command dispatcher: decodes UART command bytes against a unit table,
// activates the matching unit, waits for done/abort/timeout and sends a
// status byte back. Optional macro CMD_DISPATCH_TIMEOUT_EN adds the
// per-command watchdog and the TMO reply.
module cmd_dispatcher
    import dispatch_pkg::*;
#(
    parameter int                     N_UNITS        = 4,
    parameter logic [N_UNITS*8-1:0]   CMD_CODES      = {8'h71, 8'h22, 8'h21, 8'h11},
    parameter int                     TIMEOUT_CYCLES = 50_000_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rx_ready,
    input  logic [7:0]         rx_data,
    input  logic [N_UNITS-1:0] done,
    input  logic               tx_active,
    input  logic               tx_done,
    output logic [N_UNITS-1:0] activate,
    output logic [7:0]         state,
    output logic               busy,
    output logic               tx_start,
    output logic [7:0]         tx_data
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("cmd_dispatcher: TIMEOUT_CYCLES must be at least 2");
    end

    dispatch_state_t    fsm_q, fsm_d;
    logic [N_UNITS-1:0] activate_q, activate_d;
    logic [7:0]         state_q, state_d;
    logic               busy_q, busy_d;
    logic               tx_start_q, tx_start_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic [7:0]         reply_q, reply_d;

    logic [N_UNITS-1:0] match_oh;
    logic               match_hit;
    logic               unit_done;
    logic               abort_hit;
    logic               wdog_tc;

    // Code lookup: scan high to low so the lowest matching index wins.
    always_comb begin
        match_oh  = '0;
        match_hit = 1'b0;
        for (int i = N_UNITS - 1; i >= 0; i--) begin
            if (rx_data == CMD_CODES[i*8 +: 8]) begin
                match_oh    = '0;
                match_oh[i] = 1'b1;
                match_hit   = 1'b1;
            end
        end
    end

    // activate_q doubles as the one-hot select of the running unit, so
    // done lines of other units are masked out here.
    assign unit_done = |(done & activate_q);
    assign abort_hit = rx_ready && (rx_data == CMD_ABORT);

`ifdef CMD_DISPATCH_TIMEOUT_EN
    dispatch_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk   (clk),
        .reset (reset),
        .clr   (fsm_q != ACTIVE),
        .en    (fsm_q == ACTIVE),
        .tc    (wdog_tc)
    );
`else
    assign wdog_tc = 1'b0;
`endif

    // Next-state and registered-output computation.
    always_comb begin
        fsm_d      = fsm_q;
        activate_d = activate_q;
        state_d    = state_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        reply_d    = reply_q;

        case (fsm_q)
            IDLE: begin
                if (rx_ready) begin
                    if (match_hit) begin
                        fsm_d      = ACTIVE;
                        activate_d = match_oh;
                        state_d    = rx_data;
                    end else begin
                        fsm_d   = REPLY;
                        reply_d = REPLY_NAK;
                    end
                end
            end

            ACTIVE: begin
                // Same-cycle priority: done, then abort, then timeout.
                if (unit_done || abort_hit || wdog_tc) begin
                    fsm_d      = REPLY;
                    activate_d = '0;
                    state_d    = 8'h00;
                    if (unit_done)
                        reply_d = REPLY_ACK;
                    else if (abort_hit)
                        reply_d = REPLY_ABT;
                    else
                        reply_d = REPLY_TMO;
                end
            end

            REPLY: begin
                if (!tx_active) begin
                    fsm_d      = WAIT_TX;
                    tx_start_d = 1'b1;
                    tx_data_d  = reply_q;
                end
            end

            WAIT_TX: begin
                if (tx_done)
                    fsm_d = IDLE;
            end

            default: begin
                fsm_d      = IDLE;
                activate_d = '0;
                state_d    = 8'h00;
            end
        endcase

        busy_d = (fsm_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q      <= IDLE;
            activate_q <= '0;
            state_q    <= 8'h00;
            busy_q     <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            reply_q    <= 8'h00;
        end else begin
            fsm_q      <= fsm_d;
            activate_q <= activate_d;
            state_q    <= state_d;
            busy_q     <= busy_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            reply_q    <= reply_d;
        end
    end

    assign activate = activate_q;
    assign state    = state_q;
    assign busy     = busy_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;

endmodule
